// File: rtl/board_reset_ce_gen.sv
// Board reset sequencer and clock-enable generator.
// Merges PLL lock, the debounced board button, the key reset and the master
// reset into one stretched SYS_RST, then derives NUM_CE phase-aligned clock
// enables.
// Optional watchdog: define RSTGEN_WATCHDOG_EN to build it in.
module board_reset_ce_gen #(
    parameter int unsigned RST_CYCLES = 256,
    parameter int unsigned DEB_BITS   = 16,
    parameter int unsigned NUM_CE     = 4,
    parameter int unsigned CE_DIV_W   = 4,
    parameter logic [NUM_CE*CE_DIV_W-1:0] CE_DIV = 16'h8421,
    parameter int unsigned WDOG_BITS  = 24
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic              PLL_LOCKED,
    input  logic              BTN_nRESET,
    input  logic              KEY_RST,
    input  logic              WDOG_KICK,
    output logic              SYS_RST,
    output logic [NUM_CE-1:0] CE,
    output logic              WDOG_TRIP
);

    typedef enum logic {ST_HOLD, ST_RUN} state_t;

    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);

    // Terminal count of channel i: a zero field behaves like a ratio of 1.
    function automatic logic [CE_DIV_W-1:0] div_last(input int unsigned i);
        logic [CE_DIV_W-1:0] f;
        f = CE_DIV[i*CE_DIV_W +: CE_DIV_W];
        return (f == '0) ? '0 : f - 1'b1;
    endfunction

    logic                pll_meta_q, lock_s_q;
    logic                btn_meta_q, btn_sync_q;
    logic                btn_held_q, btn_held_d;
    logic [DEB_BITS-1:0] deb_cnt_q, deb_cnt_d;
    state_t              state_q, state_d;
    logic [15:0]         stretch_q, stretch_d;
    logic                sys_rst_q, sys_rst_d;
    logic [CE_DIV_W-1:0] cnt_q [NUM_CE];
    logic [CE_DIV_W-1:0] cnt_d [NUM_CE];
    logic [NUM_CE-1:0]   ce_q, ce_d;
    logic                wdog_fire;
    logic                req;

    // Two-flop synchronisers; the button idles in its released (high) level.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            pll_meta_q <= 1'b0;
            lock_s_q   <= 1'b0;
            btn_meta_q <= 1'b1;
            btn_sync_q <= 1'b1;
        end else begin
            pll_meta_q <= PLL_LOCKED;
            lock_s_q   <= pll_meta_q;
            btn_meta_q <= BTN_nRESET;
            btn_sync_q <= btn_meta_q;
        end
    end

    // Debounce: the held level flips only after the new level has persisted.
    always_comb begin
        deb_cnt_d  = deb_cnt_q;
        btn_held_d = btn_held_q;
        if (btn_sync_q == btn_held_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == '1) begin
            btn_held_d = ~btn_held_q;
            deb_cnt_d  = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // Debounce state register.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            deb_cnt_q  <= '0;
            btn_held_q <= 1'b1;
        end else begin
            deb_cnt_q  <= deb_cnt_d;
            btn_held_q <= btn_held_d;
        end
    end

    assign req = RESET | KEY_RST | ~lock_s_q | ~btn_held_q | wdog_fire;

    // Reset FSM: any request restarts the stretch from zero.
    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        case (state_q)
            ST_HOLD: begin
                if (req) begin
                    stretch_d = '0;
                end else if (stretch_q == RST_LAST) begin
                    state_d   = ST_RUN;
                    stretch_d = '0;
                end else begin
                    stretch_d = stretch_q + 1'b1;
                end
            end
            ST_RUN: begin
                stretch_d = '0;
                if (req) state_d = ST_HOLD;
            end
            default: begin
                state_d   = ST_HOLD;
                stretch_d = '0;
            end
        endcase
        sys_rst_d = (state_d == ST_HOLD);
    end

    // Reset FSM state and registered SYS_RST.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q   <= ST_HOLD;
            stretch_q <= '0;
            sys_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            stretch_q <= stretch_d;
            sys_rst_q <= sys_rst_d;
        end
    end

    // Phase counters; the enable is computed from next-state values so that
    // each pulse lines up with its counter sitting at zero.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CE; i++) begin
            if (sys_rst_q || cnt_q[i] == div_last(i)) cnt_d[i] = '0;
            else                                      cnt_d[i] = cnt_q[i] + 1'b1;
            ce_d[i] = ~sys_rst_d & (cnt_d[i] == '0);
        end
    end

    // Phase counter and clock-enable registers.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NUM_CE; i++) cnt_q[i] <= '0;
            ce_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CE; i++) cnt_q[i] <= cnt_d[i];
            ce_q <= ce_d;
        end
    end

`ifdef RSTGEN_WATCHDOG_EN
    logic [WDOG_BITS-1:0] wdog_q, wdog_d;

    // Watchdog: a kick on the all-ones cycle suppresses the trip.
    always_comb begin
        wdog_fire = (wdog_q == '1) & ~WDOG_KICK & ~RESET & (state_q == ST_RUN);
        wdog_d    = (WDOG_KICK | sys_rst_q) ? '0 : wdog_q + 1'b1;
    end

    // Watchdog counter register.
    always_ff @(posedge MCLK) begin
        if (RESET) wdog_q <= '0;
        else       wdog_q <= wdog_d;
    end

    assign WDOG_TRIP = wdog_fire;
`else
    logic [WDOG_BITS-1:0] unused_wdog;
    assign unused_wdog = {WDOG_BITS{WDOG_KICK}};
    assign wdog_fire   = 1'b0;
    assign WDOG_TRIP   = 1'b0;
`endif

    assign SYS_RST = sys_rst_q;
    assign CE      = ce_q;

endmodule
